// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side sequencing logic.
//   ramstate_t  : status reported by the RAM model each cycle.
//   arb_state_t : grant state of the I/D memory arbiter.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the memory arbiter.
// Counts data-side completions that happened while an instruction fetch was waiting.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : one data grant completed with the instruction side pending
//   clr_i         : clear (instruction completed, or no instruction request)
//   limit_o       : count has reached STARVE_LIMIT
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_o
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data miss-path arbiter in front of the single-ported main RAM.
// Data side has priority; after STARVE_LIMIT data grants with a fetch pending the
// instruction side is forced through. One transfer per grant, one idle bubble between.
//   CLK, nRST                     : clock, asynchronous active-low reset
//   iREN/iaddr -> iload/iwait     : instruction read port
//   dREN/dWEN/daddr/dstore
//                 -> dload/dwait  : data read/write port
//   ramREN/ramWEN/ramaddr/ramstore: RAM request (combinational from grant + live inputs)
//   ramload/ramstate              : RAM response
//   err_cnt                       : saturating count of ERROR cycles on a live grant
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ERRCNT_W     = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  logic [31:0]         iaddr,
    output logic [31:0]         iload,
    output logic                iwait,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [31:0]         daddr,
    input  logic [31:0]         dstore,
    output logic [31:0]         dload,
    output logic                dwait,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate,
    output logic [ERRCNT_W-1:0] err_cnt
);

    arb_state_t state_q, state_d;
    ramstate_t  ram_st;
    logic       dreq;
    logic       i_done, d_done, err_hit;
    logic       starve_limit;
    logic [ERRCNT_W-1:0] err_q, err_d;

    assign ram_st = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        err_hit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (starve_limit && iREN) begin
                    state_d = IGRANT;
                end else if (dreq) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                // A withdrawn request aborts before any completion/error accounting.
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_st == ACCESS) begin
                    i_done  = 1'b1;
                    state_d = IDLE;
                end else if (ram_st == ERROR) begin
                    err_hit = 1'b1;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ram_st == ACCESS) begin
                    d_done  = 1'b1;
                    state_d = IDLE;
                end else if (ram_st == ERROR) begin
                    err_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Waits are gated by nRST so every output is low while reset is held.
    assign iwait = nRST & iREN & ~i_done;
    assign dwait = nRST & dreq & ~d_done;

    always_comb begin
        err_d = err_q;
        if (err_hit && (err_q != {ERRCNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign err_cnt = err_q;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .inc_i  (d_done & iREN),
        .clr_i  (i_done | ~iREN),
        .limit_o(starve_limit)
    );

endmodule
